// File: rtl/param_pipelined_logic_unit.sv
// param_pipelined_logic_unit: 3-stage lane-pair logic unit with E/F reduction, match counter and valid/ready stalls; PLU_PARITY_EN adds o_out_parity
module param_pipelined_logic_unit #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [LANES*LANE_W-1:0] i_in_data,
    input  logic [1:0]              i_in_mode,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [LANE_W-1:0]       o_out_e,
    output logic [LANE_W-1:0]       o_out_f,
    output logic                    o_out_match,
    output logic [CNT_W-1:0]        o_match_count,
    output logic                    o_count_sat,
`ifdef PLU_PARITY_EN
    output logic                    o_out_parity,
`endif
    input  logic                    i_clr_count
);
    localparam int P = LANES / 2;

    logic                      w_adv;
    logic                      w_evt;
    logic [P-1:0][LANE_W-1:0]  w_p;
    logic [P-1:0][LANE_W-1:0]  r_p;
    logic [LANE_W-1:0]         w_e;
    logic [LANE_W-1:0]         w_f;
    logic [LANE_W-1:0]         r_e;
    logic [LANE_W-1:0]         r_f;
    logic                      r_v1;
    logic                      r_v2;
    logic                      r_v3;
    logic [LANE_W-1:0]         r_oe;
    logic [LANE_W-1:0]         r_of;
    logic                      r_om;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_sat;

    assign w_adv         = !r_v3 | i_out_ready;
    assign w_evt         = r_v3 & i_out_ready & r_om;
    assign o_in_ready    = w_adv;
    assign o_out_valid   = r_v3;
    assign o_out_e       = r_oe;
    assign o_out_f       = r_of;
    assign o_out_match   = r_om;
    assign o_match_count = r_cnt;
    assign o_count_sat   = r_sat;

    // Combine each adjacent lane pair with the selected bitwise op
    always_comb begin
        w_p = '0;
        for (int k = 0; k < P; k++) begin
            w_p[k] = i_in_mode == 2'b00 ? i_in_data[2*k*LANE_W +: LANE_W] & i_in_data[(2*k+1)*LANE_W +: LANE_W] :
                     i_in_mode == 2'b01 ? i_in_data[2*k*LANE_W +: LANE_W] | i_in_data[(2*k+1)*LANE_W +: LANE_W] :
                     i_in_mode == 2'b10 ? i_in_data[2*k*LANE_W +: LANE_W] ^ i_in_data[(2*k+1)*LANE_W +: LANE_W] :
                                          ~(i_in_data[2*k*LANE_W +: LANE_W] ^ i_in_data[(2*k+1)*LANE_W +: LANE_W]);
        end
    end

    // XOR-reduce (E) and OR-reduce (F) the registered pair results
    always_comb begin
        w_e = '0;
        w_f = '0;
        for (int k = 0; k < P; k++) begin
            w_e = w_e ^ r_p[k];
            w_f = w_f | r_p[k];
        end
    end

    // All three stages shift together only when the output slot can move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_p  <= '0;
            r_e  <= '0;
            r_f  <= '0;
            r_oe <= '0;
            r_of <= '0;
            r_om <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= i_in_valid;
            r_p  <= w_p;
            r_v2 <= r_v1;
            r_e  <= w_e;
            r_f  <= w_f;
            r_v3 <= r_v2;
            r_oe <= r_e;
            r_of <= r_f;
            r_om <= r_e == r_f;
        end
    end

`ifdef PLU_PARITY_EN
    // Parity of the output pair, registered alongside the other outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_out_parity <= 1'b0;
        else if (w_adv)
            o_out_parity <= ^{r_e, r_f};
    end
`endif

    // Saturating count of delivered matches; clear beats a same-cycle event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr_count) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_evt && !r_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_sat <= r_cnt == {{(CNT_W-1){1'b1}}, 1'b0};
        end
    end
endmodule
